// File: rtl/vlsu_req_arbiter_if.sv
// Request handshake bus between the VLSU request arbiter and the fragmenter.
// The arbiter drives the request side through the master modport.
interface vlsu_req_arbiter_if #(
    parameter int unsigned REQ_BITS = 128,
    parameter int unsigned ID_BITS  = 1
);
    logic                riva_req_valid_o;
    logic                riva_req_ready_i;
    logic [REQ_BITS-1:0] riva_req_o;
    logic [ID_BITS-1:0]  riva_src_id_o;

    modport master (
        output riva_req_valid_o,
        input  riva_req_ready_i,
        output riva_req_o,
        output riva_src_id_o
    );

    modport slave (
        input  riva_req_valid_o,
        output riva_req_ready_i,
        input  riva_req_o,
        input  riva_src_id_o
    );
endinterface

// File: rtl/vlsu_req_arbiter.sv
// Round-robin arbiter sharing the VLSU request fragmenter between NR_SRC
// sources. The granted request is registered and held until accepted; an
// outstanding counter limits in-flight requests, and direction changes wait
// for the counter to drain to zero.
// Optional statistics (grant_cnt_o, drain_cyc_o) are built when the macro
// VLSU_ARB_STATS_EN is defined.
module vlsu_req_arbiter #(
    parameter int unsigned NR_SRC          = 2,
    parameter int unsigned REQ_BITS        = 128,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_BITS        = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NR_SRC-1:0]          src_valid_i,
    output logic [NR_SRC-1:0]          src_ready_o,
    input  logic [NR_SRC*REQ_BITS-1:0] src_req_i,
    input  logic [NR_SRC-1:0]          src_is_load_i,
    vlsu_req_arbiter_if.master         riva,
    input  logic                       done_valid_i,
    output logic [CNT_BITS-1:0]        outstanding_o,
    output logic                       busy_o,
    output logic                       err_o
`ifdef VLSU_ARB_STATS_EN
    ,
    output logic [NR_SRC*16-1:0]       grant_cnt_o,
    output logic [15:0]                drain_cyc_o
`endif
);
    localparam int unsigned ID_BITS = $clog2(NR_SRC);
    localparam logic [ID_BITS-1:0] LAST_IDX = ID_BITS'(NR_SRC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ID_BITS-1:0]  rr_ptr;
    logic [ID_BITS-1:0]  win_idx;
    logic                win_found;
    logic                win_dir;
    logic                last_dir;
    logic                dir_ok;
    logic                credit_ok;
    logic                grant;
    logic                accept;
    logic [CNT_BITS-1:0] cnt;
    logic                err;

    assign credit_ok     = (cnt < CNT_BITS'(MAX_OUTSTANDING));
    assign win_dir       = src_is_load_i[win_idx];
    assign dir_ok        = (cnt == '0) || (win_dir == last_dir);
    assign grant         = (state == S_IDLE) && win_found && dir_ok;
    assign accept        = riva.riva_req_valid_o & riva.riva_req_ready_i;
    assign outstanding_o = cnt;
    assign err_o         = err;
    assign busy_o        = (cnt != '0) | riva.riva_req_valid_o;

    // Winner search: first eligible source starting at rr_ptr, wrapping modulo NR_SRC.
    always_comb begin
        int unsigned pos;
        pos       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NR_SRC; i++) begin
            pos = 32'(rr_ptr) + i;
            if (pos >= NR_SRC) begin
                pos = pos - NR_SRC;
            end
            if (!win_found && credit_ok && src_valid_i[ID_BITS'(pos)]) begin
                win_found = 1'b1;
                win_idx   = ID_BITS'(pos);
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    state_next = dir_ok ? S_HOLD : S_DRAIN;
                end
            end
            S_HOLD: begin
                if (riva.riva_req_ready_i) begin
                    state_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (cnt == '0) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs: ready only on an issuable grant in S_IDLE, valid while holding.
    always_comb begin
        src_ready_o           = '0;
        riva.riva_req_valid_o = (state == S_HOLD);
        if (grant) begin
            src_ready_o[win_idx] = 1'b1;
        end
    end

    // Latch the granted request and advance the round-robin pointer past the winner.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            riva.riva_req_o    <= '0;
            riva.riva_src_id_o <= '0;
            last_dir           <= 1'b0;
            rr_ptr             <= '0;
        end else if (grant) begin
            riva.riva_req_o    <= src_req_i[32'(win_idx)*REQ_BITS +: REQ_BITS];
            riva.riva_src_id_o <= win_idx;
            last_dir           <= win_dir;
            rr_ptr             <= (win_idx == LAST_IDX) ? '0 : win_idx + ID_BITS'(1);
        end
    end

    // Outstanding counter: +1 on accept, -1 on completion, sticky error on underflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (accept && !done_valid_i) begin
            cnt <= cnt + CNT_BITS'(1);
        end else if (done_valid_i && !accept) begin
            if (cnt == '0) begin
                err <= 1'b1;
            end else begin
                cnt <= cnt - CNT_BITS'(1);
            end
        end
    end

`ifdef VLSU_ARB_STATS_EN
    // Per-source saturating accept counters.
    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < NR_SRC; k++) begin
            if (rst_i) begin
                grant_cnt_o[k*16 +: 16] <= '0;
            end else if (accept && (riva.riva_src_id_o == ID_BITS'(k)) &&
                         (grant_cnt_o[k*16 +: 16] != '1)) begin
                grant_cnt_o[k*16 +: 16] <= grant_cnt_o[k*16 +: 16] + 16'd1;
            end
        end
    end

    // Saturating count of cycles spent draining before a direction change.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drain_cyc_o <= '0;
        end else if ((state == S_DRAIN) && (drain_cyc_o != '1)) begin
            drain_cyc_o <= drain_cyc_o + 16'd1;
        end
    end
`endif
endmodule
